// File: rtl/pid_chan_pipeline.sv
// Multi-channel clamped PID datapath: 4-cycle accept-to-dv_out latency, rdy_out drops while the incoming
// channel still has a sample in S1..S3. Optional macro PID_ANTI_WINDUP_EN freezes the integrator while saturated.
module pid_chan_pipeline #(
  parameter int N_CHAN    = 8,
  parameter int W_CHAN    = 3,
  parameter int W_DIN     = 18,
  parameter int W_DOUT    = 18,
  parameter int W_COEF    = 16,
  parameter int W_ACC     = 48,
  parameter int W_RS      = 6,
  parameter int W_WR_ADDR = 16,
  parameter int W_WR_CHAN = 16,
  parameter int W_WR_DATA = 48,
  parameter logic [W_WR_ADDR-1:0] ADDR_BASE = 16'h0100
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 dv_in,
  input  logic [W_CHAN-1:0]    chan_in,
  input  logic [W_DIN-1:0]     data_in,
  output logic                 rdy_out,
  input  logic                 wr_en,
  input  logic [W_WR_ADDR-1:0] wr_addr,
  input  logic [W_WR_CHAN-1:0] wr_chan,
  input  logic [W_WR_DATA-1:0] wr_data,
  output logic                 dv_out,
  output logic [W_CHAN-1:0]    chan_out,
  output logic [W_DOUT-1:0]    data_out,
  output logic                 sat_out
);
  localparam int W_E = W_DIN + 1;
  localparam int W_X = W_ACC + 2;
  localparam logic signed [W_X-1:0] SAT_HI = W_X'({1'b0, {(W_ACC-1){1'b1}}});
  localparam logic signed [W_X-1:0] SAT_LO = -SAT_HI;

  function automatic logic signed [W_X-1:0] f_sx(input logic signed [W_ACC-1:0] a);
    return {{2{a[W_ACC-1]}}, a};
  endfunction

  function automatic logic signed [W_ACC-1:0] f_sat(input logic signed [W_X-1:0] x);
    if (x > SAT_HI)      return SAT_HI[W_ACC-1:0];
    else if (x < SAT_LO) return SAT_LO[W_ACC-1:0];
    else                 return x[W_ACC-1:0];
  endfunction

  logic signed [W_DIN-1:0]  r_sp  [N_CHAN];
  logic signed [W_COEF-1:0] r_kp  [N_CHAN];
  logic signed [W_COEF-1:0] r_ki  [N_CHAN];
  logic signed [W_COEF-1:0] r_kd  [N_CHAN];
  logic [W_RS-1:0]          r_rs  [N_CHAN];
  logic signed [W_DOUT-1:0] r_min [N_CHAN];
  logic signed [W_DOUT-1:0] r_max [N_CHAN];
  logic [N_CHAN-1:0]        r_en;
  logic signed [W_ACC-1:0]  r_acc   [N_CHAN];
  logic signed [W_E-1:0]    r_eprev [N_CHAN];

  logic                     r_s1_vld, r_s2_vld, r_s3_vld;
  logic [W_CHAN-1:0]        r_s1_chan, r_s2_chan, r_s3_chan;
  logic                     r_s1_en, r_s2_en, r_s3_en;
  logic [W_RS-1:0]          r_s1_rs, r_s2_rs, r_s3_rs;
  logic signed [W_DOUT-1:0] r_s1_min, r_s2_min, r_s3_min, r_s1_max, r_s2_max, r_s3_max;
  logic signed [W_E-1:0]    r_s1_e, r_s1_ep, r_s2_e;
  logic signed [W_COEF-1:0] r_s1_kp, r_s1_ki, r_s1_kd;
  logic signed [W_ACC-1:0]  r_s1_acc, r_s2_acc, r_s2_p, r_s2_i, r_s2_d, r_s3_u;

  logic [W_WR_ADDR-1:0]     w_off;
  logic [W_CHAN-1:0]        w_wch;
  logic                     w_hit, w_clr, w_accept, w_hold, w_sat, w_unused_ok;
  logic signed [W_E-1:0]    w_e;
  logic signed [W_E:0]      w_de;
  logic signed [W_ACC-1:0]  w_p, w_i, w_d, w_acc_new, w_u, w_v, w_mn, w_mx, w_o;

  assign w_off       = wr_addr - ADDR_BASE;
  assign w_wch       = wr_chan[W_CHAN-1:0];
  assign w_hit       = wr_en && (wr_addr >= ADDR_BASE) && (w_off <= W_WR_ADDR'(8)) &&
                       (wr_chan < W_WR_CHAN'(N_CHAN));
  assign w_clr       = w_hit && (w_off == W_WR_ADDR'(8));
  assign w_unused_ok = ^wr_data;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < N_CHAN; c++) begin
        r_sp[c]  <= '0;
        r_kp[c]  <= '0;
        r_ki[c]  <= '0;
        r_kd[c]  <= '0;
        r_rs[c]  <= '0;
        r_min[c] <= {1'b1, {(W_DOUT-1){1'b0}}};
        r_max[c] <= {1'b0, {(W_DOUT-1){1'b1}}};
      end
      r_en <= '0;
    end else if (w_hit) begin
      case (w_off[3:0])
        4'd0:    r_sp[w_wch]  <= wr_data[W_DIN-1:0];
        4'd1:    r_kp[w_wch]  <= wr_data[W_COEF-1:0];
        4'd2:    r_ki[w_wch]  <= wr_data[W_COEF-1:0];
        4'd3:    r_kd[w_wch]  <= wr_data[W_COEF-1:0];
        4'd4:    r_rs[w_wch]  <= wr_data[W_RS-1:0];
        4'd5:    r_min[w_wch] <= wr_data[W_DOUT-1:0];
        4'd6:    r_max[w_wch] <= wr_data[W_DOUT-1:0];
        4'd7:    r_en[w_wch]  <= wr_data[0];
        default: ;
      endcase
    end
  end

  // A same-channel sample anywhere in S1..S3 would read stale acc/e_prev.
  assign rdy_out  = !((r_s1_vld && (r_s1_chan == chan_in)) ||
                      (r_s2_vld && (r_s2_chan == chan_in)) ||
                      (r_s3_vld && (r_s3_chan == chan_in)));
  assign w_accept = dv_in && rdy_out;
  assign w_e      = {r_sp[chan_in][W_DIN-1], r_sp[chan_in]} - {data_in[W_DIN-1], data_in};

  assign w_de = {r_s1_e[W_E-1], r_s1_e} - {r_s1_ep[W_E-1], r_s1_ep};
  assign w_p  = W_ACC'(r_s1_kp) * W_ACC'(r_s1_e);
  assign w_i  = W_ACC'(r_s1_ki) * W_ACC'(r_s1_e);
  assign w_d  = W_ACC'(r_s1_kd) * W_ACC'(w_de);

`ifdef PID_ANTI_WINDUP_EN
  logic [1:0] r_flag [N_CHAN];
  assign w_hold = (r_flag[r_s2_chan][1] && !r_s2_i[W_ACC-1] && (r_s2_i != '0)) ||
                  (r_flag[r_s2_chan][0] && r_s2_i[W_ACC-1]);
`else
  assign w_hold = 1'b0;
`endif
  assign w_acc_new = w_hold ? r_s2_acc : f_sat(f_sx(r_s2_acc) + f_sx(r_s2_i));
  assign w_u       = f_sat(f_sx(r_s2_p) + f_sx(w_acc_new) + f_sx(r_s2_d));

  assign w_v  = r_s3_u >>> r_s3_rs;
  assign w_mn = W_ACC'(r_s3_min);
  assign w_mx = W_ACC'(r_s3_max);
  always_comb begin
    w_o = w_v;
    if (w_mn > w_mx)      w_o = w_mn;
    else if (w_v > w_mx)  w_o = w_mx;
    else if (w_v < w_mn)  w_o = w_mn;
  end
  assign w_sat = (w_o != w_v);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s3_vld <= 1'b0;
      dv_out   <= 1'b0;
      chan_out <= '0;
      data_out <= '0;
      sat_out  <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
      r_s2_vld <= r_s1_vld;
      r_s3_vld <= r_s2_vld;
      dv_out   <= r_s3_vld && r_s3_en;
      if (r_s3_vld && r_s3_en) begin
        chan_out <= r_s3_chan;
        data_out <= w_o[W_DOUT-1:0];
        sat_out  <= w_sat;
      end
    end
  end

  // Payload registers carry no reset; the valid chain qualifies them.
  always_ff @(posedge clk_in) begin
    r_s1_chan <= chan_in;
    r_s1_e    <= w_e;
    r_s1_acc  <= r_acc[chan_in];
    r_s1_ep   <= r_eprev[chan_in];
    r_s1_kp   <= r_kp[chan_in];
    r_s1_ki   <= r_ki[chan_in];
    r_s1_kd   <= r_kd[chan_in];
    r_s1_rs   <= r_rs[chan_in];
    r_s1_min  <= r_min[chan_in];
    r_s1_max  <= r_max[chan_in];
    r_s1_en   <= r_en[chan_in];
    r_s2_chan <= r_s1_chan;
    r_s2_en   <= r_s1_en;
    r_s2_e    <= r_s1_e;
    r_s2_acc  <= r_s1_acc;
    r_s2_p    <= w_p;
    r_s2_i    <= w_i;
    r_s2_d    <= w_d;
    r_s2_rs   <= r_s1_rs;
    r_s2_min  <= r_s1_min;
    r_s2_max  <= r_s1_max;
    r_s3_chan <= r_s2_chan;
    r_s3_en   <= r_s2_en;
    r_s3_u    <= w_u;
    r_s3_rs   <= r_s2_rs;
    r_s3_min  <= r_s2_min;
    r_s3_max  <= r_s2_max;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < N_CHAN; c++) begin
        r_acc[c]   <= '0;
        r_eprev[c] <= '0;
      end
    end else begin
      if (r_s2_vld) begin
        r_acc[r_s2_chan]   <= r_s2_en ? w_acc_new : '0;
        r_eprev[r_s2_chan] <= r_s2_en ? r_s2_e : '0;
      end
      if (w_clr) begin
        r_acc[w_wch]   <= '0;
        r_eprev[w_wch] <= '0;
      end
    end
  end

`ifdef PID_ANTI_WINDUP_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < N_CHAN; c++) r_flag[c] <= 2'b00;
    end else begin
      if (r_s3_vld)
        r_flag[r_s3_chan] <= r_s3_en ? {w_sat && (w_v > w_o), w_sat && (w_v < w_o)} : 2'b00;
      if (w_clr)
        r_flag[w_wch] <= 2'b00;
    end
  end
`endif
endmodule

// File: tb/tb_pid_chan_pipeline.sv
// Scoreboard bench for pid_chan_pipeline: directed scenarios plus random traffic checked against
// a per-sample arithmetic model of the PID rules.
module tb_pid_chan_pipeline;
  localparam int NC = 8;
  localparam logic [15:0] BASE = 16'h0100;
  localparam longint LIM = (longint'(1) <<< 47) - 1;

  logic        clk_in = 1'b0;
  logic        rst_in, dv_in, rdy_out, wr_en, dv_out, sat_out;
  logic [2:0]  chan_in, chan_out;
  logic [17:0] data_in, data_out;
  logic [15:0] wr_addr, wr_chan;
  logic [47:0] wr_data;

  pid_chan_pipeline dut (
    .clk_in(clk_in), .rst_in(rst_in), .dv_in(dv_in), .chan_in(chan_in), .data_in(data_in),
    .rdy_out(rdy_out), .wr_en(wr_en), .wr_addr(wr_addr), .wr_chan(wr_chan), .wr_data(wr_data),
    .dv_out(dv_out), .chan_out(chan_out), .data_out(data_out), .sat_out(sat_out)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0, fails = 0, cyc = 0, n_out = 0;
  longint last_dat = 0;
  bit last_sat = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct { int ch; longint dat; bit sat; int at; } exp_t;
  exp_t sb[$];

  longint m_sp[NC], m_kp[NC], m_ki[NC], m_kd[NC], m_rs[NC], m_mn[NC], m_mx[NC], m_acc[NC], m_ep[NC];
  bit     m_en[NC], m_fhi[NC], m_flo[NC];
  int     last_acc[NC];

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint sx(input longint v, input int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint sat48(input longint x);
    return (x > LIM) ? LIM : ((x < -LIM) ? -LIM : x);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_sp[c] = 0; m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0; m_rs[c] = 0;
      m_mn[c] = -131072; m_mx[c] = 131071; m_en[c] = 0;
      m_acc[c] = 0; m_ep[c] = 0; m_fhi[c] = 0; m_flo[c] = 0; last_acc[c] = -100;
    end
    sb.delete();
  endtask

  task automatic model_write(input int off, input int ch, input logic [47:0] d);
    longint v = longint'(d);
    if (ch >= NC || off > 8) return;
    case (off)
      0: m_sp[ch] = sx(v, 18);
      1: m_kp[ch] = sx(v, 16);
      2: m_ki[ch] = sx(v, 16);
      3: m_kd[ch] = sx(v, 16);
      4: m_rs[ch] = v & 63;
      5: m_mn[ch] = sx(v, 18);
      6: m_mx[ch] = sx(v, 18);
      7: m_en[ch] = d[0];
      default: begin m_acc[ch] = 0; m_ep[ch] = 0; m_fhi[ch] = 0; m_flo[ch] = 0; end
    endcase
  endtask

  // One sample through the PID rules, in arrival order per channel.
  task automatic model_sample(input int ch, input int din);
    longint e, p, i, d, u, v, o;
    bit hold, s;
    exp_t x;
    e = m_sp[ch] - sx(longint'(din), 18);
    p = m_kp[ch] * e;
    i = m_ki[ch] * e;
    d = m_kd[ch] * (e - m_ep[ch]);
    hold = 0;
`ifdef PID_ANTI_WINDUP_EN
    hold = (m_fhi[ch] && i > 0) || (m_flo[ch] && i < 0);
`endif
    if (!m_en[ch]) begin
      m_acc[ch] = 0; m_ep[ch] = 0; m_fhi[ch] = 0; m_flo[ch] = 0;
      return;
    end
    if (!hold) m_acc[ch] = sat48(m_acc[ch] + i);
    m_ep[ch] = e;
    u = sat48(p + m_acc[ch] + d);
    v = u >>> m_rs[ch];
    if (m_mn[ch] > m_mx[ch]) o = m_mn[ch];
    else if (v > m_mx[ch])   o = m_mx[ch];
    else if (v < m_mn[ch])   o = m_mn[ch];
    else                     o = v;
    s = (o != v);
    m_fhi[ch] = s && (v > o);
    m_flo[ch] = s && (v < o);
    x.ch = ch; x.dat = o; x.sat = s; x.at = cyc + 4;
    sb.push_back(x);
  endtask

  task automatic cfg(input int off, input int ch, input longint val);
    wr_en = 1'b1; wr_addr = BASE + 16'(off); wr_chan = 16'(ch); wr_data = 48'(val);
    @(posedge clk_in); #1;
    wr_en = 1'b0;
    model_write(off, ch, 48'(val));
  endtask

  task automatic try_send(input int ch, input int din, output bit ok);
    bit exp_rdy;
    dv_in = 1'b1; chan_in = 3'(ch); data_in = 18'(din);
    exp_rdy = (cyc - last_acc[ch]) >= 4;
    @(negedge clk_in);
    check("rdy_out", rdy_out, exp_rdy);
    ok = exp_rdy;
    if (ok) begin
      last_acc[ch] = cyc;
      model_sample(ch, din);
    end
    @(posedge clk_in); #1;
    dv_in = 1'b0;
  endtask

  task automatic send(input int ch, input int din, output int tries);
    bit ok = 0;
    tries = 0;
    while (!ok && tries < 8) begin
      try_send(ch, din, ok);
      tries++;
    end
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin tick(1); n++; end
    tick(2);
    check("drain_outstanding", sb.size(), 0);
    sb.delete();
  endtask

  always @(negedge clk_in) begin
    exp_t x;
    if (!rst_in && dv_out) begin
      n_out++;
      last_dat = longint'($signed(data_out));
      last_sat = sat_out;
      if (sb.size() == 0) begin
        check("unexpected_dv_out", 1, 0);
      end else begin
        x = sb.pop_front();
        check("chan_out", chan_out, x.ch);
        check("data_out", $signed(data_out), x.dat);
        check("sat_out", sat_out, x.sat);
        check("latency_cycle", cyc, x.at);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n0, off;
    longint exp_w;
    bit ok;
    dv_in = 0; chan_in = 0; data_in = 0; wr_en = 0; wr_addr = 0; wr_chan = 0; wr_data = 0;
    rst_in = 1'b1;
    model_reset();
    tick(3);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("rst_dv_out", dv_out, 0);
    check("rst_chan_out", chan_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_sat_out", sat_out, 0);
    check("rst_rdy_out", rdy_out, 1);
    @(posedge clk_in); #1;

    // Proportional
    cfg(0, 2, 100); cfg(1, 2, 2); cfg(7, 2, 1);
    send(2, 40, t); drain();
    check("prop_value", last_dat, 120);
    check("prop_sat", last_sat, 0);

    // Integrator, then clear strobe
    cfg(1, 2, 0); cfg(2, 2, 1);
    for (int k = 1; k <= 3; k++) begin
      send(2, 90, t); drain();
      check("integ_value", last_dat, 10 * k);
    end
    cfg(8, 2, 0);
    send(2, 90, t); drain();
    check("integ_after_clear", last_dat, 10);

    // Same-channel hazard, then distinct channels back to back
    cfg(1, 2, 2); cfg(2, 2, 0);
    send(2, 40, t);
    send(2, 41, t);
    check("hazard_tries", t, 4);
    drain();
    for (int c = 3; c <= 5; c++) begin cfg(0, c, 100); cfg(1, c, 2); cfg(7, c, 1); end
    for (int c = 2; c <= 5; c++) begin
      send(c, 10 * c, t);
      check("no_stall_tries", t, 1);
    end
    drain();

    // Clamp high and low
    cfg(0, 1, 100); cfg(1, 1, 1000); cfg(6, 1, 500); cfg(7, 1, 1);
    send(1, 0, t); drain();
    check("clamp_hi_value", last_dat, 500);
    check("clamp_hi_sat", last_sat, 1);
    cfg(5, 1, -500);
    send(1, 200, t); drain();
    check("clamp_lo_value", last_dat, -500);
    check("clamp_lo_sat", last_sat, 1);

    // Out-of-range channel write must not alias onto channel 1
    cfg(1, 9, 0);
    send(1, 0, t); drain();
    check("wr_chan9_ignored", last_dat, 500);

    // Disabled channel yields nothing
    cfg(7, 3, 0);
    n0 = n_out;
    send(3, 10, t); tick(10);
    check("disabled_no_dv_out", n_out - n0, 0);

    // Integrator windup under saturation
    cfg(1, 1, 0); cfg(2, 1, 1000); cfg(8, 1, 0);
    for (int k = 0; k < 5; k++) begin send(1, 0, t); drain(); end
    cfg(6, 1, 131071); cfg(5, 1, -131072);
    send(1, 100, t); drain();
`ifdef PID_ANTI_WINDUP_EN
    exp_w = 100000;
`else
    exp_w = 131071;
`endif
    check("windup_value", last_dat, exp_w);

    // Reset with samples in flight
    send(2, 1, t); send(4, 2, t); send(5, 3, t);
    n0 = n_out;
    rst_in = 1'b1;
    model_reset();
    tick(2);
    rst_in = 1'b0;
    @(negedge clk_in);
    check("midrst_dv_out", dv_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_chan_out", chan_out, 0);
    check("midrst_sat_out", sat_out, 0);
    @(posedge clk_in); #1;
    tick(8);
    check("midrst_no_dv_out", n_out - n0, 0);

    // Random traffic
    for (int c = 0; c < NC; c++) begin
      cfg(0, c, $urandom); cfg(1, c, $urandom); cfg(2, c, $urandom); cfg(3, c, $urandom);
      cfg(4, c, $urandom_range(0, 20));
      cfg(5, c, ($urandom_range(0, 4) == 0) ? longint'($urandom) : -longint'($urandom_range(1000, 131072)));
      cfg(6, c, ($urandom_range(0, 4) == 0) ? longint'($urandom) : longint'($urandom_range(1000, 131071)));
      cfg(7, c, ($urandom_range(0, 4) != 0) ? 1 : 0);
    end
    for (int k = 0; k < 600; k++) begin
      case ($urandom_range(0, 9))
        0: begin
          off = $urandom_range(0, 14);
          if (off >= 8) off++;
          cfg(off, $urandom_range(0, 11), {$urandom, $urandom});
        end
        1, 2: tick(1);
        default: try_send($urandom_range(0, NC - 1), $urandom, ok);
      endcase
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pid_chan_pipeline.md
Name: pid_chan_pipeline

Overview:
Self-contained, parametrised multi-channel PID datapath. It is the next generation of the oversample/PID/output chain and has per-channel state and a fixed pipeline latency. It accepts channel-tagged samples and computes a clamped PID output per channel. It applies backpressure (rdy_out) when a new sample would hit a read-after-write hazard on the same channel's state. It sits between instr_dispatch/oversample_filter and the DAC/output routing, and is configured over the shared wr_en/wr_addr/wr_chan/wr_data bus.

Parameters:
N_CHAN, 8, number of channels
W_CHAN, 3, channel tag width
W_DIN, 18, signed input sample width
W_DOUT, 18, signed output width
W_COEF, 16, signed P/I/D coefficient width
W_ACC, 48, signed integrator/sum width
W_RS, 6, right-shift field width
W_WR_ADDR, 16, config address width
W_WR_CHAN, 16, config channel width
W_WR_DATA, 48, config data width
ADDR_BASE, 16'h0100, base of this block's register window

Ports:
clk_in  in  1  clock
rst_in  in  1  reset
dv_in  in  1  input sample valid
chan_in  in  W_CHAN  input channel tag
data_in  in  W_DIN  signed input sample
rdy_out  out  1  block can accept a sample this cycle
wr_en  in  1  config write strobe
wr_addr  in  W_WR_ADDR  config address
wr_chan  in  W_WR_CHAN  config target channel
wr_data  in  W_WR_DATA  config data (LSB-aligned, truncated to field width)
dv_out  out  1  output valid, one-cycle pulse
chan_out  out  W_CHAN  output channel tag
data_out  out  W_DOUT  signed clamped PID output
sat_out  out  1  data_out was clamped this sample

Behaviour:
- Clock and reset: single clock clk_in; rst_in is synchronous, active-high.
- Reset clears:
  - all pipeline valids, dv_out, chan_out, data_out, sat_out to 0.
  - per-channel integrator and e_prev to 0.
  - setpoint, P, I, D and rshift to 0; enable to 0.
  - min to -2^(W_DOUT-1); max to 2^(W_DOUT-1)-1.
  - Reset mid-operation discards all in-flight samples; no dv_out follows.
- Register map, offset from ADDR_BASE, indexed by wr_chan:
  - +0 setpoint (W_DIN), +1 P, +2 I, +3 D (W_COEF), +4 rshift (W_RS), +5 min (W_DOUT), +6 max (W_DOUT), +7 enable (bit 0).
  - +8 is a write-only strobe that clears the integrator and e_prev.
  - Writes with wr_chan >= N_CHAN or an unmapped offset are ignored.
  - Config takes effect for samples entering stage S1 on the cycle after the write.
- Accept rule: a sample is accepted when dv_in && rdy_out. dv_in while rdy_out=0 is ignored; the upstream must hold or resend.
- rdy_out is combinational: rdy_out = !(chan_in matches the tag of any valid sample in S1, S2 or S3).
- Pipeline, latency 4 cycles from accept to dv_out:
  - S1: e = setpoint - data_in, (W_DIN+1)-bit signed; fetch acc and e_prev.
  - S2: p = P*e; i = I*e; d = D*(e - e_prev); all sign-extended to W_ACC.
  - S3: acc' = sat_W_ACC(acc + i). Write back acc' and e_prev=e at the S3 clock edge. u = sat_W_ACC(p + acc' + d).
  - S4: v = u >>> rshift (arithmetic). data_out = clamp(v, min, max); sat_out = 1 if clamped. dv_out=1 for one cycle.
- Saturation is symmetric-limit: ±(2^(W_ACC-1)-1).
- If min > max, data_out = min.
- Disabled channel (enable=0): sample is consumed and its state is held at 0; no dv_out.
- Config write to a channel whose sample is in flight: the in-flight sample uses already-latched values. The strobe at +8 wins over an S3 write-back in the same cycle.

Optional Feature:
- Macro: PID_ANTI_WINDUP_EN.
- Defined: each channel keeps a 2-bit last-saturation flag (high/low) from S4. In S3, acc is not updated if the flag is set and i has the same sign as that saturation direction.
- Undefined: the integrator is limited only by W_ACC saturation; the flags are not present.

Test Plan:
- Setup for the first three scenarios: ch2 setpoint=100, P=2, I=0, D=0, rshift=0, enable=1.
- Proportional: data_in=40 on ch2 -> dv_out 4 cycles after accept, chan_out=2, data_out=120, sat_out=0.
- Integrator: ch2 with P=0, I=1, three samples of data_in=90 spaced >=4 cycles -> data_out 10, 20, 30; then strobe +8 -> next output 10.
- Hazard: ch2 then ch2 on consecutive cycles -> rdy_out=0 for 3 cycles, second sample accepted on the 4th cycle. ch2, ch3, ch4, ch5 back-to-back -> no stall, outputs in order.
- Clamp: ch1 P=1000, max=500, data_in=0, setpoint=100 -> data_out=500, sat_out=1. Negative case with min=-500 -> data_out=-500.
- Reset/disable:
  - rst_in asserted with 3 samples in flight -> no dv_out; all outputs 0.
  - Write to wr_chan=9 -> no effect.
  - enable=0 channel -> no dv_out.
- Anti-windup (PID_ANTI_WINDUP_EN): ch1 I=1000, max=500, 5 saturating samples -> integrator stops growing after the first saturation. Without the macro it keeps growing.
